// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: mode encoding, FSM states
// and the bit-ordering helpers used by the transmit shifter.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    // Encoded as {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    function automatic logic first_bit(input logic [SPI_BYTE_W-1:0] b, input logic lsb);
        return lsb ? b[0] : b[SPI_BYTE_W-1];
    endfunction

    // Moves the next bit to be transmitted into the first_bit position.
    function automatic logic [SPI_BYTE_W-1:0] shift_next(input logic [SPI_BYTE_W-1:0] b,
                                                         input logic lsb);
        return lsb ? {1'b0, b[SPI_BYTE_W-1:1]} : {b[SPI_BYTE_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise and
// fall pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{idle}};
            prev  <= idle;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI responder: oversamples sclk/ss/mosi in the pclk domain, receives MOSI
// bytes and returns MISO bytes from a one-deep transmit holding register.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic [SPI_BYTE_W-1:0] txdata,
    input  logic                  txvalid,
    output logic                  txready,
    output logic [SPI_BYTE_W-1:0] rxdata,
    output logic                  rxvalid,
    output logic                  underrun,
    output logic                  frame_err,
    output logic                  busy
);

    spi_state_e state_q, state_d;
    spi_mode_e  mode_q;
    logic       cpol_l, cpha_l, lsbfe_l;

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    logic [SPI_BYTE_W-1:0] tx_hold, tx_shift, rx_shift, rx_next, load_byte;
    logic                  hold_full;
    logic [2:0]            count, rx_idx;

    logic start, stop, sample_en, shift_en;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic load, load_lsb, accept;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (pclk),
        .rst  (preset),
        .idle (cpol),
        .d    (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (pclk),
        .rst  (preset),
        .idle (1'b1),
        .d    (ss),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // Same depth as sclk so data and clock edges stay aligned.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) mosi_chain <= '0;
        else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    assign {cpol_l, cpha_l} = mode_q;
    assign lead_edge   = cpol_l ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_l ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ss rising wins over any sclk edge in the same cycle.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        stop      = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    shift_en  = shift_edge;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // cpha=0 reloads on the shift edge after the 8th sample; cpha=1 on the 8th sample itself.
    assign load      = start
                     | (shift_en  & ~cpha_l & (count == 3'd0))
                     | (sample_en &  cpha_l & (count == 3'd7));
    assign load_lsb  = start ? lsbfe : lsbfe_l;
    assign load_byte = hold_full ? tx_hold : DEFAULT_TX;
    assign accept    = txvalid & ~hold_full;
    assign txready   = ~hold_full;
    assign busy      = (state_q == ACTIVE);

    // A load in the accept cycle consumes the old contents; the new byte stays held.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tx_hold   <= '0;
            hold_full <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= load & ~hold_full;
            if (accept) begin
                tx_hold   <= txdata;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            mode_q   <= MODE0;
            lsbfe_l  <= 1'b0;
            tx_shift <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            if (start) begin
                mode_q  <= spi_mode_e'({cpol, cpha});
                lsbfe_l <= lsbfe;
                miso_oe <= 1'b1;
            end
            if (load) begin
                tx_shift <= load_byte;
                miso     <= first_bit(load_byte, load_lsb);
            end else if (shift_en) begin
                tx_shift <= shift_next(tx_shift, lsbfe_l);
                if (cpha_l) miso <= first_bit(tx_shift, lsbfe_l);
                else        miso <= first_bit(shift_next(tx_shift, lsbfe_l), lsbfe_l);
            end
            if (stop) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end
        end
    end

    assign rx_idx = lsbfe_l ? count : (3'd7 - count);

    always_comb begin
        rx_next         = rx_shift;
        rx_next[rx_idx] = mosi_s;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx_shift  <= '0;
            count     <= '0;
            rxdata    <= '0;
            rxvalid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxvalid   <= 1'b0;
            frame_err <= stop & (count != 3'd0);
            if (start || stop) begin
                rx_shift <= '0;
                count    <= '0;
            end else if (sample_en) begin
                rx_shift <= rx_next;
                count    <= count + 3'd1;
                if (count == 3'd7) begin
                    rxdata  <= rx_next;
                    rxvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: drives SPI frames in all modes and
// compares MISO bytes, received data and status pulses against fixed values.
module tb_spi_slave_responder;

    localparam int HALF = 8;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       lsbfe = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       txvalid = 1'b0;
    logic       miso, miso_oe, txready, rxvalid, underrun, frame_err, busy;
    logic [7:0] rxdata;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int rxv_cnt   = 0;
    int und_cnt   = 0;
    int ferr_cnt  = 0;
    int txr_rise  = 0;
    logic txr_prev = 1'b1;

    spi_slave_responder #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsbfe     (lsbfe),
        .txdata    (txdata),
        .txvalid   (txvalid),
        .txready   (txready),
        .rxdata    (rxdata),
        .rxvalid   (rxvalid),
        .underrun  (underrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (rxvalid)   rxv_cnt++;
        if (underrun)  und_cnt++;
        if (frame_err) ferr_cnt++;
        if (txready && !txr_prev) txr_rise++;
        txr_prev = txready;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "simulation timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb);
        cpol  = pol;
        cpha  = pha;
        lsbfe = lsb;
        sclk  = pol;
        tick(HALF);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int waited = 0;
        while (!txready && waited < 50) begin
            tick(1);
            waited++;
        end
        if (!txready) begin
            check_cnt++;
            $display("FAIL push_tx_timeout: got txready=%b expected 1", txready);
        end
        txdata  = b;
        txvalid = 1'b1;
        tick(1);
        txvalid = 1'b0;
    endtask

    task automatic start_frame();
        ss = 1'b0;
        tick(HALF);
    endtask

    task automatic end_frame();
        tick(HALF);
        ss = 1'b1;
        tick(HALF);
    endtask

    // Captures MISO just before each sample edge into the bit position it represents.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbfe ? i : 7 - i;
            if (!cpha) begin
                mosi = tx[idx];
                tick(HALF);
                rx[idx] = miso;
                sclk = ~sclk;
                tick(HALF);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = tx[idx];
                tick(HALF);
                rx[idx] = miso;
                sclk = ~sclk;
                tick(HALF);
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick(3);
        check_cnt++;
        if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso);
        else pass_cnt++;
        check_cnt++;
        if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b expected 0", miso_oe);
        else pass_cnt++;
        check_cnt++;
        if (txready !== 1'b1) $display("FAIL reset_txready: got %b expected 1", txready);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h00) $display("FAIL reset_rxdata: got %h expected 00", rxdata);
        else pass_cnt++;
        check_cnt++;
        if ({rxvalid, underrun, frame_err, busy} !== 4'b0000)
            $display("FAIL reset_pulses: got %b expected 0000", {rxvalid, underrun, frame_err, busy});
        else pass_cnt++;
        preset = 1'b0;
        tick(3);
    endtask

    task automatic test_mode2_lsb();
        logic [7:0] got;
        int rxv0, und0;
        set_mode(1'b1, 1'b0, 1'b1);
        push_tx(8'h46);
        rxv0 = rxv_cnt;
        und0 = und_cnt;
        start_frame();
        check_cnt++;
        if ({busy, miso_oe, txready} !== 3'b111)
            $display("FAIL mode2_start: got %b expected 111", {busy, miso_oe, txready});
        else pass_cnt++;
        push_tx(8'h5A);
        xfer(8'h46, 8, got);
        end_frame();
        check_cnt++;
        if (got !== 8'h46) $display("FAIL mode2_miso: got %h expected 46", got);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h46) $display("FAIL mode2_rxdata: got %h expected 46", rxdata);
        else pass_cnt++;
        check_cnt++;
        if (rxv_cnt - rxv0 !== 1) $display("FAIL mode2_rxvalid: got %0d expected 1", rxv_cnt - rxv0);
        else pass_cnt++;
        check_cnt++;
        if (und_cnt - und0 !== 0) $display("FAIL mode2_underrun: got %0d expected 0", und_cnt - und0);
        else pass_cnt++;
        check_cnt++;
        if ({busy, miso_oe, miso} !== 3'b000)
            $display("FAIL mode2_idle: got %b expected 000", {busy, miso_oe, miso});
        else pass_cnt++;
    endtask

    task automatic test_mode0_msb();
        logic [7:0] got;
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'hA5);
        start_frame();
        push_tx(8'h11);
        xfer(8'h3C, 8, got);
        end_frame();
        check_cnt++;
        if (got !== 8'hA5) $display("FAIL mode0_miso: got %h expected a5", got);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h3C) $display("FAIL mode0_rxdata: got %h expected 3c", rxdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got0, got1;
        int rxv0, txr0;
        set_mode(1'b1, 1'b1, 1'b0);
        push_tx(8'hC3);
        rxv0 = rxv_cnt;
        txr0 = txr_rise;
        start_frame();
        push_tx(8'h81);
        check_cnt++;
        if (txready !== 1'b0) $display("FAIL b2b_txready_full: got %b expected 0", txready);
        else pass_cnt++;
        xfer(8'h12, 8, got0);
        check_cnt++;
        if (rxdata !== 8'h12) $display("FAIL b2b_rxdata0: got %h expected 12", rxdata);
        else pass_cnt++;
        xfer(8'h34, 8, got1);
        end_frame();
        check_cnt++;
        if (got0 !== 8'hC3) $display("FAIL b2b_miso0: got %h expected c3", got0);
        else pass_cnt++;
        check_cnt++;
        if (got1 !== 8'h81) $display("FAIL b2b_miso1: got %h expected 81", got1);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h34) $display("FAIL b2b_rxdata1: got %h expected 34", rxdata);
        else pass_cnt++;
        check_cnt++;
        if (rxv_cnt - rxv0 !== 2) $display("FAIL b2b_rxvalid: got %0d expected 2", rxv_cnt - rxv0);
        else pass_cnt++;
        check_cnt++;
        if (txr_rise - txr0 !== 2) $display("FAIL b2b_txready_rises: got %0d expected 2", txr_rise - txr0);
        else pass_cnt++;
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        int und0;
        set_mode(1'b0, 1'b0, 1'b1);
        und0 = und_cnt;
        start_frame();
        check_cnt++;
        if (und_cnt - und0 !== 1) $display("FAIL underrun_at_start: got %0d expected 1", und_cnt - und0);
        else pass_cnt++;
        push_tx(8'h00);
        xfer(8'h5C, 8, got);
        end_frame();
        check_cnt++;
        if (got !== 8'hFF) $display("FAIL underrun_miso: got %h expected ff", got);
        else pass_cnt++;
        check_cnt++;
        if (und_cnt - und0 !== 1) $display("FAIL underrun_count: got %0d expected 1", und_cnt - und0);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h5C) $display("FAIL underrun_rxdata: got %h expected 5c", rxdata);
        else pass_cnt++;
    endtask

    task automatic test_frame_err();
        logic [7:0] got;
        int rxv0, ferr0;
        set_mode(1'b0, 1'b0, 1'b1);
        rxv0  = rxv_cnt;
        ferr0 = ferr_cnt;
        start_frame();
        push_tx(8'h99);
        xfer(8'h1F, 5, got);
        end_frame();
        check_cnt++;
        if (ferr_cnt - ferr0 !== 1) $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - ferr0);
        else pass_cnt++;
        check_cnt++;
        if (rxv_cnt - rxv0 !== 0) $display("FAIL ferr_rxvalid: got %0d expected 0", rxv_cnt - rxv0);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h5C) $display("FAIL ferr_rxdata: got %h expected 5c", rxdata);
        else pass_cnt++;
        check_cnt++;
        if (txready !== 1'b0) $display("FAIL ferr_hold_kept: got %b expected 0", txready);
        else pass_cnt++;
        start_frame();
        xfer(8'hA0, 8, got);
        end_frame();
        check_cnt++;
        if (got !== 8'h99) $display("FAIL ferr_next_miso: got %h expected 99", got);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'hA0) $display("FAIL ferr_next_rxdata: got %h expected a0", rxdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] got;
        int rxv0, ferr0;
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'h42);
        start_frame();
        push_tx(8'h77);
        xfer(8'hFF, 3, got);
        @(posedge pclk);
        #3 preset = 1'b1;
        #1;
        check_cnt++;
        if ({miso, miso_oe, busy, txready} !== 4'b0001)
            $display("FAIL midreset_outputs: got %b expected 0001", {miso, miso_oe, busy, txready});
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'h00) $display("FAIL midreset_rxdata: got %h expected 00", rxdata);
        else pass_cnt++;
        ss   = 1'b1;
        sclk = cpol;
        tick(2);
        preset = 1'b0;
        tick(4);
        push_tx(8'h3C);
        rxv0  = rxv_cnt;
        ferr0 = ferr_cnt;
        start_frame();
        push_tx(8'h00);
        xfer(8'hE7, 8, got);
        end_frame();
        check_cnt++;
        if (got !== 8'h3C) $display("FAIL midreset_next_miso: got %h expected 3c", got);
        else pass_cnt++;
        check_cnt++;
        if (rxdata !== 8'hE7) $display("FAIL midreset_next_rxdata: got %h expected e7", rxdata);
        else pass_cnt++;
        check_cnt++;
        if (rxv_cnt - rxv0 !== 1) $display("FAIL midreset_rxvalid: got %0d expected 1", rxv_cnt - rxv0);
        else pass_cnt++;
        check_cnt++;
        if (ferr_cnt - ferr0 !== 0) $display("FAIL midreset_ferr: got %0d expected 0", ferr_cnt - ferr0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mode2_lsb();
        test_mode0_msb();
        test_back_to_back();
        test_underrun();
        test_frame_err();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
